eth_mii_tx_framer: RTL

ETH_MII_TX_FRAMER -- requirements
Module: eth_mii_tx_framer

---
 rtl/eth_mii_tx_framer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/eth_mii_tx_framer.sv
// eth_mii_tx_framer: MII nibble transmitter that wraps a byte stream with preamble/SFD,
// zero padding to a minimum length, CRC-32 FCS and an enforced inter-frame gap.
module eth_mii_tx_framer #(
    parameter int MIN_BYTES   = 60,
    parameter int IFG_NIBBLES = 24
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [3:0] mii_txd,
    output logic       mii_tx_en,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);
    typedef enum logic [3:0] {IDLE, PREAMBLE, SFD, DATA_LO, DATA_HI, PAD_LO, PAD_HI, FCS, IFG} state_t;
    state_t      state_q;
    logic [7:0]  byte_q;
    logic        last_q;
    logic [15:0] count_q;
    logic [15:0] cnt_q;
    logic [31:0] crc_q;
    logic [31:0] fcs;
    logic        pad_needed;

    // Reflected CRC-32 advanced by one wire nibble (bit 0 first).
    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
        logic [31:0] r;
        r = c ^ {28'd0, n};
        for (int i = 0; i < 4; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    assign fcs        = ~crc_q;
    assign pad_needed = int'(count_q) < MIN_BYTES;

    // state_q names what the registered outputs are driving in the current cycle.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            last_q     <= 1'b0;
            count_q    <= '0;
            cnt_q      <= '0;
            crc_q      <= '1;
            s_ready    <= 1'b0;
            mii_txd    <= '0;
            mii_tx_en  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            case (state_q)
                IDLE: if (s_valid) begin
                    state_q   <= PREAMBLE;
                    cnt_q     <= 16'd1;
                    count_q   <= '0;
                    crc_q     <= '1;
                    mii_tx_en <= 1'b1;
                    mii_txd   <= 4'h5;
                    busy      <= 1'b1;
                end
                PREAMBLE: if (cnt_q == 16'd15) begin
                    state_q <= SFD;
                    mii_txd <= 4'hD;
                    s_ready <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                SFD, DATA_HI, PAD_HI: if (s_ready && s_valid) begin
                    state_q <= DATA_LO;
                    byte_q  <= s_data;
                    last_q  <= s_last;
                    count_q <= count_q + {15'd0, ~&count_q};
                    mii_txd <= s_data[3:0];
                    crc_q   <= crc_nib(crc_q, s_data[3:0]);
                    s_ready <= 1'b0;
                end else if (s_ready) begin
                    state_q   <= IFG;
                    cnt_q     <= 16'd1;
                    mii_tx_en <= 1'b0;
                    mii_txd   <= '0;
                    s_ready   <= 1'b0;
                    underrun  <= 1'b1;
                end else if (pad_needed) begin
                    state_q <= PAD_LO;
                    count_q <= count_q + 16'd1;
                    mii_txd <= '0;
                    crc_q   <= crc_nib(crc_q, 4'h0);
                end else begin
                    state_q <= FCS;
                    cnt_q   <= '0;
                    mii_txd <= fcs[3:0];
                end
                DATA_LO: begin
                    state_q <= DATA_HI;
                    mii_txd <= byte_q[7:4];
                    crc_q   <= crc_nib(crc_q, byte_q[7:4]);
                    s_ready <= !last_q;
                end
                PAD_LO: begin
                    state_q <= PAD_HI;
                    mii_txd <= '0;
                    crc_q   <= crc_nib(crc_q, 4'h0);
                end
                FCS: if (cnt_q == 16'd7) begin
                    state_q    <= IFG;
                    cnt_q      <= 16'd1;
                    mii_tx_en  <= 1'b0;
                    mii_txd    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    cnt_q   <= cnt_q + 16'd1;
                    mii_txd <= fcs[{cnt_q[2:0] + 3'd1, 2'b00} +: 4];
                end
                IFG: if (int'(cnt_q) >= IFG_NIBBLES) begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
